// File: rtl/seq_pkg.sv
// Shared types and constants for the 8-step display sequencer.
package seq_pkg;

  localparam int IDX_W = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } state_e;

  // Entry i is the digit shown at position i.
  localparam logic [7:0][3:0] NUM_TABLE = {
    4'd7, 4'd5, 4'd2, 4'd15,
    4'd12, 4'd9, 4'd6, 4'd3
  };

endpackage

// File: rtl/rate_tick.sv
// Period counter: strobes once every FPGA_FREQ or FPGA_FREQ/2 cycles while enabled.
module rate_tick #(
  parameter int FPGA_FREQ = 50_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic tiempo,
  output logic tick
);

  localparam int CW = $clog2(FPGA_FREQ);
  localparam logic [CW-1:0] LAST_SLOW = CW'(FPGA_FREQ - 1);
  localparam logic [CW-1:0] LAST_FAST = CW'(FPGA_FREQ / 2 - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] last;

  always_comb begin
    last = tiempo ? LAST_SLOW : LAST_FAST;
    // Compare against the live period so a rate change applies mid-period.
    tick = en && !reset && (cnt_q >= last);
    cnt_d = '0;
    if (en && !tick) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/seq_controller.sv
// Run/pause/step sequencer walking an 8-entry digit table.
module seq_controller
  import seq_pkg::*;
#(
  parameter int FPGA_FREQ = 50_000_000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
  input  logic             step,
  input  logic             clear,
  input  logic             up,
  input  logic             tiempo,
  output logic [IDX_W-1:0] idx,
  output logic [3:0]       num,
  output logic             tick,
  output logic             running,
  output logic             wrap
);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             wrap_q, wrap_d;
  logic             adv;

  rate_tick #(
    .FPGA_FREQ(FPGA_FREQ)
  ) u_rate (
    .clk   (clk),
    .reset (reset),
    .en    (state_q == RUN),
    .tiempo(tiempo),
    .tick  (tick)
  );

  always_comb begin
    state_d = state_q;
    adv     = 1'b0;
    if (clear) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (stop) state_d = IDLE;
          else if (start) state_d = RUN;
          else if (step) begin
            adv     = 1'b1;
            state_d = PAUSE;
          end
        end
        RUN: begin
          if (stop) state_d = PAUSE;
          else if (tick) adv = 1'b1;
        end
        PAUSE: begin
          if (stop) state_d = PAUSE;
          else if (start) state_d = RUN;
          else if (step) adv = 1'b1;
        end
        default: state_d = IDLE;
      endcase
    end
    idx_d = idx_q;
    if (clear) idx_d = '0;
    else if (adv) idx_d = up ? idx_q + 1'b1 : idx_q - 1'b1;
    wrap_d = adv && !clear &&
             (up ? (idx_q == '1) : (idx_q == '0));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      wrap_q  <= wrap_d;
    end
  end

  assign idx     = idx_q;
  assign num     = NUM_TABLE[idx_q];
  assign running = (state_q == RUN);
  assign wrap    = wrap_q;

endmodule

// File: tb/tb_seq_controller.sv
// Directed plus random checks of seq_controller against a cycle model.
module tb_seq_controller;

  localparam int FF = 8;
  localparam int M_IDLE = 0;
  localparam int M_RUN = 1;
  localparam int M_PAUSE = 2;

  logic       clk = 1'b0;
  logic       reset, start, stop, step, clear, up, tiempo;
  logic [2:0] idx;
  logic [3:0] num;
  logic       tick, running, wrap;

  int n_vec = 0;
  int n_bad = 0;

  int m_mode = M_IDLE;
  int m_idx = 0;
  int m_cnt = 0;
  int m_wrap = 0;
  int m_tick;
  int digits[8] = '{3, 6, 9, 12, 15, 2, 5, 7};

  seq_controller #(.FPGA_FREQ(FF)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .stop   (stop),
    .step   (step),
    .clear  (clear),
    .up     (up),
    .tiempo (tiempo),
    .idx    (idx),
    .num    (num),
    .tick   (tick),
    .running(running),
    .wrap   (wrap)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, got, exp);
    end
  endtask

  // One clock: drive, check outputs, then advance the model.
  task automatic cyc(input bit r, input bit sa, input bit so,
                     input bit se, input bit cl, input bit u, input bit t);
    int period, adv, nmode, nidx;
    @(negedge clk);
    reset = r; start = sa; stop = so; step = se;
    clear = cl; up = u; tiempo = t;
    #1;
    period = t ? FF : FF / 2;
    m_tick = (!r && m_mode == M_RUN && m_cnt >= period - 1) ? 1 : 0;
    chk("tick", int'(tick), m_tick);
    chk("idx", int'(idx), m_idx);
    chk("num", int'(num), digits[m_idx]);
    chk("running", int'(running), (m_mode == M_RUN) ? 1 : 0);
    chk("wrap", int'(wrap), m_wrap);
    adv = 0;
    nmode = m_mode;
    nidx = m_idx;
    if (cl) begin
      nmode = M_IDLE;
      nidx = 0;
    end else if (m_mode == M_RUN) begin
      if (so) nmode = M_PAUSE;
      else if (m_tick != 0) adv = 1;
    end else if (so) begin
      nmode = m_mode;
    end else if (sa) begin
      nmode = M_RUN;
    end else if (se) begin
      adv = 1;
      nmode = M_PAUSE;
    end
    if (adv != 0) nidx = u ? (m_idx + 1) % 8 : (m_idx + 7) % 8;
    m_wrap = (adv != 0 && (u ? m_idx == 7 : m_idx == 0)) ? 1 : 0;
    m_cnt = (m_mode == M_RUN && m_tick == 0) ? m_cnt + 1 : 0;
    m_mode = nmode;
    m_idx = nidx;
    if (r) begin
      m_mode = M_IDLE;
      m_idx = 0;
      m_cnt = 0;
      m_wrap = 0;
    end
  endtask

  task automatic idle_n(input int n, input bit u, input bit t);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, u, t);
  endtask

  task automatic run_to_idx(input int target, input bit u, input bit t);
    for (int i = 0; i < 200 && m_idx != target; i++)
      cyc(0, 0, 0, 0, 0, u, t);
    chk("reach_idx", m_idx, target);
  endtask

  initial begin
    reset = 1; start = 0; stop = 0; step = 0;
    clear = 0; up = 1; tiempo = 1;
    cyc(1, 0, 0, 0, 0, 1, 1);
    cyc(1, 0, 0, 0, 1, 1, 1);
    @(negedge clk); #1;
    chk("rst_idx", int'(idx), 0);
    chk("rst_num", int'(num), 3);
    chk("rst_run", int'(running), 0);

    // Full forward lap at the slow rate.
    cyc(0, 1, 0, 0, 0, 1, 1);
    idle_n(8 * 8 + 4, 1, 1);

    // Reverse at the fast rate from 0.
    cyc(0, 0, 0, 0, 1, 1, 1);
    cyc(0, 1, 0, 0, 0, 0, 0);
    idle_n(14, 0, 0);

    // Stop coinciding with a tick, then three steps.
    for (int i = 0; i < 20 && !(m_mode == M_RUN && m_cnt == 3); i++)
      cyc(0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 1, 0, 0, 1, 0);
    for (int i = 0; i < 3; i++) begin
      cyc(0, 0, 0, 1, 0, 1, 0);
      cyc(0, 0, 0, 0, 0, 1, 0);
    end

    // Rate change while cnt = 6.
    cyc(0, 1, 0, 0, 0, 1, 1);
    for (int i = 0; i < 20 && m_cnt != 6; i++)
      cyc(0, 0, 0, 0, 0, 1, 1);
    chk("cnt6", m_cnt, 6);
    idle_n(10, 1, 0);

    // Clear and start together in RUN at idx 5.
    run_to_idx(5, 1, 0);
    idle_n(2, 1, 0);
    cyc(0, 1, 0, 0, 1, 1, 0);
    idle_n(2, 1, 0);

    // Reset with step mid-RUN at idx 4.
    cyc(0, 1, 0, 0, 0, 1, 0);
    run_to_idx(4, 1, 0);
    idle_n(3, 1, 0);
    cyc(1, 0, 0, 1, 0, 1, 0);
    idle_n(3, 1, 0);

    // Random pulses.
    for (int i = 0; i < 3000; i++) begin
      bit r, sa, so, se, cl;
      r  = ($urandom_range(0, 199) == 0);
      sa = ($urandom_range(0, 19) == 0);
      so = ($urandom_range(0, 29) == 0);
      se = ($urandom_range(0, 14) == 0);
      cl = ($urandom_range(0, 59) == 0);
      cyc(r, sa, so, se, cl, 1'($urandom_range(0, 1)),
          ($urandom_range(0, 9) != 0) ? tiempo : ~tiempo);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
